// File: rtl/video_timing_gen.sv
// 640x480@60 raster timing source: counters, sync/active decode, enable-gated delay line.
// Optional colour-bar test pattern on red/green/blue when VTG_TEST_PATTERN_EN is defined.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          SYNC_POL   = 1'b0,
   parameter int unsigned PIPE_DELAY = 2
) (
   input  logic        pixel_clk,
   input  logic        arstn,
   input  logic        en,
   output logic [9:0]  drawX,
   output logic [9:0]  drawY,
   output logic        hsync,
   output logic        vsync,
   output logic        vde,
   output logic        hsync_d,
   output logic        vsync_d,
   output logic        vde_d,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_counter,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue
);

   localparam int unsigned XW      = 10;
   localparam int unsigned YW      = 10;
   localparam int unsigned FCW     = 16;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
   localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
   localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic          SYNC_INACT = ~SYNC_POL;

   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [FCW-1:0] fc_q, fc_d;
   logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic           ls_q, ls_d, fs_q, fs_d;
   logic           run_q;
   logic           x_wrap, y_wrap;

   // Next raster position and its decode; outputs register these so they line up with drawX/drawY.
   always_comb begin
      x_wrap = (x_q >= X_LAST);
      y_wrap = (y_q >= Y_LAST);
      x_d    = x_wrap ? '0 : x_q + XW'(1);
      y_d    = y_q;
      if (x_wrap) begin
         y_d = y_wrap ? '0 : y_q + YW'(1);
      end else if (y_q > Y_LAST) begin
         y_d = '0;
      end
      // The wrap out of the post-reset parking position does not complete a frame.
      fc_d = fc_q + FCW'(x_wrap && y_wrap && run_q);
      hs_d = (x_d >= HS_FIRST && x_d <= HS_LAST) ? SYNC_POL : SYNC_INACT;
      vs_d = (y_d >= VS_FIRST && y_d <= VS_LAST) ? SYNC_POL : SYNC_INACT;
      de_d = (x_d < X_ACT) && (y_d < Y_ACT);
      ls_d = (x_d == '0);
      fs_d = ls_d && (y_d == '0);
   end

   always_ff @(posedge pixel_clk) begin
      if (!arstn) begin
         x_q   <= X_LAST;
         y_q   <= Y_LAST;
         fc_q  <= '0;
         hs_q  <= SYNC_INACT;
         vs_q  <= SYNC_INACT;
         de_q  <= 1'b0;
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
         run_q <= 1'b0;
      end else if (en) begin
         x_q   <= x_d;
         y_q   <= y_d;
         fc_q  <= fc_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         de_q  <= de_d;
         ls_q  <= ls_d;
         fs_q  <= fs_d;
         run_q <= 1'b1;
      end else begin
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
      end
   end

`ifdef VTG_TEST_PATTERN_EN
   localparam int unsigned PIPE_W = 15;
   localparam int unsigned BAR_W  = 80;

   logic [11:0] rgb_q, rgb_d;
   logic [2:0]  bar;

   // Eight 80-pixel colour bars, blanked outside active video.
   always_comb begin
      bar   = 3'(x_d / XW'(BAR_W));
      rgb_d = '0;
      if (de_d) begin
         case (bar)
            3'd0:    rgb_d = 12'hFFF;
            3'd1:    rgb_d = 12'hFF0;
            3'd2:    rgb_d = 12'h0FF;
            3'd3:    rgb_d = 12'h0F0;
            3'd4:    rgb_d = 12'hF0F;
            3'd5:    rgb_d = 12'hF00;
            3'd6:    rgb_d = 12'h00F;
            default: rgb_d = 12'h000;
         endcase
      end
   end

   always_ff @(posedge pixel_clk) begin
      if (!arstn) begin
         rgb_q <= '0;
      end else if (en) begin
         rgb_q <= rgb_d;
      end
   end
`else
   localparam int unsigned PIPE_W = 3;
`endif

   localparam logic [PIPE_W-1:0] PIPE_RST = PIPE_W'({SYNC_INACT, SYNC_INACT, 1'b0});

   logic [PIPE_W-1:0] pipe_in, pipe_out;

`ifdef VTG_TEST_PATTERN_EN
   assign pipe_in = {rgb_q, hs_q, vs_q, de_q};
`else
   assign pipe_in = {hs_q, vs_q, de_q};
`endif

   // Enable-gated delay line keeping sync/active (and pattern) aligned with the pixel path.
   generate
      if (PIPE_DELAY == 0) begin : g_nodly
         assign pipe_out = pipe_in;
      end else begin : g_dly
         localparam int unsigned SRW = PIPE_DELAY * PIPE_W;
         logic [SRW-1:0] sr_q;
         always_ff @(posedge pixel_clk) begin
            if (!arstn) begin
               sr_q <= {PIPE_DELAY{PIPE_RST}};
            end else if (en) begin
               sr_q <= SRW'({sr_q, pipe_in});
            end
         end
         assign pipe_out = sr_q[SRW-1 -: PIPE_W];
      end
   endgenerate

   assign drawX         = x_q;
   assign drawY         = y_q;
   assign hsync         = hs_q;
   assign vsync         = vs_q;
   assign vde           = de_q;
   assign line_start    = ls_q;
   assign frame_start   = fs_q;
   assign frame_counter = fc_q;
   assign hsync_d       = pipe_out[2];
   assign vsync_d       = pipe_out[1];
   assign vde_d         = pipe_out[0];

`ifdef VTG_TEST_PATTERN_EN
   assign red   = pipe_out[14:11];
   assign green = pipe_out[10:7];
   assign blue  = pipe_out[6:3];
`else
   assign red   = 4'h0;
   assign green = 4'h0;
   assign blue  = 4'h0;
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-rate video timing source for the HDMI text controller: 640x480@60 timing, 800x525 total raster.
- Produces the drawX/drawY/hsync/vsync/vde signals that the draw logic consumes and the simulation bench captures into its bitmap.
- Provides pipeline-delayed copies of hsync/vsync/vde so they stay aligned with a multi-cycle pixel path.
- Provides a frame counter and line/frame start pulses.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
V_ACTIVE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
SYNC_POL, 0, sync active level (0 = active-low)
PIPE_DELAY, 2, cycles of delay on *_d outputs (0..8)

Ports:
pixel_clk  in  1  pixel clock (25 MHz)
arstn  in  1  reset, synchronous, active-low; clock pixel_clk
en  in  1  advance enable; low freezes the raster
drawX  out  10  current horizontal count 0..H_TOTAL-1
drawY  out  10  current vertical count 0..V_TOTAL-1
hsync  out  1  horizontal sync, aligned with drawX/drawY
vsync  out  1  vertical sync, aligned with drawX/drawY
vde  out  1  active video, aligned with drawX/drawY
hsync_d  out  1  hsync delayed PIPE_DELAY enabled cycles
vsync_d  out  1  vsync delayed PIPE_DELAY enabled cycles
vde_d  out  1  vde delayed PIPE_DELAY enabled cycles
line_start  out  1  one-cycle pulse when drawX==0
frame_start  out  1  one-cycle pulse when drawX==0 && drawY==0
frame_counter  out  16  completed-frame count
red  out  4  test-pattern red (see Optional Feature)
green  out  4  test-pattern green
blue  out  4  test-pattern blue

Behaviour:
- Reset (arstn low at posedge): drawX=H_TOTAL-1 (799), drawY=V_TOTAL-1 (524), hsync=vsync=!SYNC_POL (inactive), vde=0, line_start=frame_start=0, frame_counter=0. Delay line and rgb pipeline all inactive / 0.
- First enabled edge after reset yields drawX=0, drawY=0, vde=1, line_start=1, frame_start=1. Reset mid-frame behaves identically.
- Counting (en=1):
  - drawX increments each cycle and wraps H_TOTAL-1 -> 0.
  - On that wrap, drawY increments and wraps V_TOTAL-1 -> 0.
  - On drawY wrap, frame_counter increments (wraps 0xFFFF -> 0).
  - frame_counter updates on the same edge that produces (0,0).
- Decode: all outputs are registered, computed from next-count values, so they match the drawX/drawY present in the same cycle.
  - vde = drawX<H_ACTIVE && drawY<V_ACTIVE.
  - hsync active when drawX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vsync active when drawY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], for the entire line, including blanking.
- en=0: counters, hsync/vsync/vde, frame_counter, delay line and rgb pipeline all hold. line_start and frame_start are forced 0 while en=0. Resume continues from the held position.
- Delay line: a PIPE_DELAY-stage shift register on {hsync,vsync,vde} that advances only when en=1. PIPE_DELAY=0 means *_d equal the undelayed outputs (wire-through).
- Reset has priority over en.
- No state machine beyond the two counters; no illegal states are reachable. A counter value >= its total is forced to 0 on the next enabled edge.

Optional Feature:
- Macro VTG_TEST_PATTERN_EN.
- Defined: red/green/blue carry 8 vertical color bars, each 80 px wide, bar = drawX/80. Order: white(F,F,F), yellow(F,F,0), cyan(0,F,F), green(0,F,0), magenta(F,0,F), red(F,0,0), blue(0,0,F), black(0,0,0).
  - Value is 0 whenever vde=0.
  - Pipelined PIPE_DELAY enabled cycles, so it aligns with vde_d; holds when en=0.
- Undefined: red/green/blue tied to 0; no pattern logic synthesized.

Test Plan:
- Reset 4 cycles, release with en=1 -> first edge drawX=0, drawY=0, vde=1, frame_start=1, line_start=1, hsync=vsync=1. Next edge drawX=1, frame_start=0.
- Run one line -> hsync low for exactly 96 consecutive cycles, drawX 656..751. vde high for drawX 0..639 on lines 0..479. line_start period 800 cycles.
- Run one frame (420000 cycles) -> vsync low for 1600 cycles, starting at (0,490). frame_counter 0->1 on the edge producing (0,0). frame_start period 420000.
- Drop en for 10 cycles at (100,5) -> all outputs hold at (100,5), line_start=0. Release -> next edge (101,5).
- PIPE_DELAY=2 -> vde_d/hsync_d/vsync_d equal vde/hsync/vsync from 2 cycles earlier. Reset asserted at (300,200) -> next edge reset values, vde_d=0 for 2 enabled cycles after release.
- With VTG_TEST_PATTERN_EN, PIPE_DELAY=2 -> pixel at drawX=85 appears 2 cycles later as rgb=(F,F,0) with vde_d=1. Pixel at drawX=700 -> rgb=(0,0,0), vde_d=0.
